// File: rtl/cmip_trig_window_gen_pkg.sv
// Shared CMIP trigger-window constants and state encoding.
// Imported by the window generator and its instantiating tops.
package cmip_trig_window_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_WIN_LEN     = 4096;
  localparam int unsigned DEF_HOLDOFF_CLK = 64;
  localparam int unsigned DEF_ID_W        = 16;
  localparam int unsigned MISS_W          = 16;

endpackage

// File: rtl/cmip_trig_window_gen.sv
// Trigger-driven capture window: frames WIN_LEN valid samples with SOF/EOF,
// frame ID, post-window hold-off and a saturating missed-trigger count.
module cmip_trig_window_gen
  import cmip_trig_window_gen_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WIN_LEN     = DEF_WIN_LEN,
  parameter int unsigned HOLDOFF_CLK = DEF_HOLDOFF_CLK,
  parameter int unsigned ID_W        = DEF_ID_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_trig,
  input  logic              i_din_vld,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_dout_vld,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_sof,
  output logic              o_eof,
  output logic [ID_W-1:0]   o_frame_id,
  output logic              o_busy,
  output logic [MISS_W-1:0] o_miss_cnt
);

  localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_LEN - 1);

  localparam int unsigned HOLD_W =
    (HOLDOFF_CLK > 1) ? $clog2(HOLDOFF_CLK) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT =
    HOLD_W'((HOLDOFF_CLK > 0) ? HOLDOFF_CLK - 1 : 0);
  localparam bit HAS_HOLD = (HOLDOFF_CLK != 0);

  state_e              state_q, state_d;
  logic                trig_dly_q, trig_dly_d;
  logic [CNT_W-1:0]    smp_cnt_q, smp_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]     frame_id_q, frame_id_d;
  logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic                dout_vld_q, dout_vld_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                sof_q, sof_d;
  logic                eof_q, eof_d;
  logic                busy_q, busy_d;
  logic                trig_pos;

  always_comb begin
    trig_pos   = i_trig & ~trig_dly_q;
    trig_dly_d = i_trig;
    state_d    = state_q;
    smp_cnt_d  = smp_cnt_q;
    hold_cnt_d = hold_cnt_q;
    frame_id_d = frame_id_q;
    miss_cnt_d = miss_cnt_q;
    dout_vld_d = 1'b0;
    dout_d     = dout_q;
    sof_d      = 1'b0;
    eof_d      = 1'b0;

    if (i_clr) begin
      state_d    = ST_IDLE;
      smp_cnt_d  = '0;
      hold_cnt_d = '0;
      frame_id_d = '0;
      miss_cnt_d = '0;
    end else begin
      if (trig_pos && (state_q != ST_IDLE) && (miss_cnt_q != '1)) begin
        miss_cnt_d = miss_cnt_q + MISS_W'(1);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (i_en && trig_pos) begin
            state_d   = ST_CAPTURE;
            smp_cnt_d = '0;
          end
        end
        ST_CAPTURE: begin
          if (i_din_vld) begin
            dout_vld_d = 1'b1;
            dout_d     = i_din;
            sof_d      = (smp_cnt_q == '0);
            eof_d      = (smp_cnt_q == LAST);
            smp_cnt_d  = smp_cnt_q + CNT_W'(1);
            if (smp_cnt_q == LAST) begin
              frame_id_d = frame_id_q + ID_W'(1);
              if (HAS_HOLD) begin
                state_d    = ST_HOLDOFF;
                hold_cnt_d = HOLD_INIT;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // busy mirrors the state being entered so it drops with IDLE re-entry
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      trig_dly_q <= 1'b0;
      smp_cnt_q  <= '0;
      hold_cnt_q <= '0;
      frame_id_q <= '0;
      miss_cnt_q <= '0;
      dout_vld_q <= 1'b0;
      dout_q     <= '0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_dly_q <= trig_dly_d;
      smp_cnt_q  <= smp_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      frame_id_q <= frame_id_d;
      miss_cnt_q <= miss_cnt_d;
      dout_vld_q <= dout_vld_d;
      dout_q     <= dout_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      busy_q     <= busy_d;
    end
  end

  assign o_dout_vld = dout_vld_q;
  assign o_dout     = dout_q;
  assign o_sof      = sof_q;
  assign o_eof      = eof_q;
  assign o_frame_id = frame_id_q;
  assign o_busy     = busy_q;
  assign o_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_cmip_trig_window_gen.sv
// Bench for cmip_trig_window_gen: two configurations (8/4 and 1/0) share
// stimulus and are checked each cycle against an abstract window model.
module tb_cmip_trig_window_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        trig = 1'b0;
  logic        dvld = 1'b0;
  logic [15:0] din = '0;

  logic        a_vld, a_sof, a_eof, a_busy;
  logic [15:0] a_dout, a_fid, a_miss;
  logic        b_vld, b_sof, b_eof, b_busy;
  logic [15:0] b_dout, b_fid, b_miss;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cmip_trig_window_gen #(
    .DATA_W(16), .WIN_LEN(8), .HOLDOFF_CLK(4), .ID_W(16)
  ) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr),
    .i_trig(trig), .i_din_vld(dvld), .i_din(din),
    .o_dout_vld(a_vld), .o_dout(a_dout), .o_sof(a_sof), .o_eof(a_eof),
    .o_frame_id(a_fid), .o_busy(a_busy), .o_miss_cnt(a_miss)
  );

  cmip_trig_window_gen #(
    .DATA_W(16), .WIN_LEN(1), .HOLDOFF_CLK(0), .ID_W(16)
  ) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr),
    .i_trig(trig), .i_din_vld(dvld), .i_din(din),
    .o_dout_vld(b_vld), .o_dout(b_dout), .o_sof(b_sof), .o_eof(b_eof),
    .o_frame_id(b_fid), .o_busy(b_busy), .o_miss_cnt(b_miss)
  );

  logic [51:0] act_a, act_b;
  assign act_a = {a_vld, a_dout, a_sof, a_eof, a_fid, a_busy, a_miss};
  assign act_b = {b_vld, b_dout, b_sof, b_eof, b_fid, b_busy, b_miss};

  // Abstract model: a window is open or not, with beats taken so far and
  // remaining hold-off clocks as plain integers.
  typedef struct {
    bit          inwin;
    int          done;
    int          hold;
    bit          ptrig;
    bit          vld;
    logic [15:0] dout;
    bit          sof;
    bit          eof;
    int          frame;
    int          miss;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mzero();
    mdl_t m;
    m = '{default: 0};
    m.dout = 16'h0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int win, int hold);
    bit rise;
    rise = trig && !m.ptrig;
    m.ptrig = trig;
    m.vld = 0;
    m.sof = 0;
    m.eof = 0;
    if (clr) begin
      m.inwin = 0;
      m.hold = 0;
      m.done = 0;
      m.frame = 0;
      m.miss = 0;
      return m;
    end
    if (rise && (m.inwin || m.hold > 0) && m.miss < 65535) m.miss++;
    if (m.inwin) begin
      if (dvld) begin
        m.vld = 1;
        m.dout = din;
        m.sof = (m.done == 0);
        m.eof = (m.done == win - 1);
        m.done++;
        if (m.done == win) begin
          m.inwin = 0;
          m.frame = (m.frame + 1) % 65536;
          m.hold = hold;
        end
      end
    end else if (m.hold > 0) begin
      m.hold--;
    end else if (en && rise) begin
      m.inwin = 1;
      m.done = 0;
    end
    return m;
  endfunction

  function automatic logic [51:0] expv(mdl_t m);
    logic busy;
    logic [15:0] f, x;
    busy = m.inwin || (m.hold > 0);
    f = m.frame[15:0];
    x = m.miss[15:0];
    return {m.vld, m.dout, m.sof, m.eof, f, busy, x};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= mzero();
      mb <= mzero();
    end else begin
      ma <= mstep(ma, 8, 4);
      mb <= mstep(mb, 1, 0);
    end
  end

  task automatic drv(input logic e, c, t, v, input logic [15:0] d);
    en = e;
    clr = c;
    trig = t;
    dvld = v;
    din = d;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drv(0, 0, 0, 0, 16'h0);
    drv(0, 0, 0, 0, 16'h0);
    n_chk++;
    if ({act_a, act_b} !== 104'h0) begin
      n_fail++;
      $display("FAIL reset_outputs act=%h/%h exp=0", act_a, act_b);
    end
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 16'h0);
    n_chk++;
    if ({act_a, act_b} !== {expv(ma), expv(mb)}) begin
      n_fail++;
      $display("FAIL reset_model act=%h/%h exp=%h/%h",
               act_a, act_b, expv(ma), expv(mb));
    end
  endtask

  task automatic test_basic();
    int nb = 0;
    for (int k = 0; k < 16; k++) begin
      drv(1, 0, k == 0, 1, 16'(16'h0100 + k));
      n_chk++;
      if ({act_a, act_b} !== {expv(ma), expv(mb)}) begin
        n_fail++;
        $display("FAIL basic_model k=%0d act=%h/%h exp=%h/%h",
                 k, act_a, act_b, expv(ma), expv(mb));
      end
      if (a_vld) begin
        nb++;
        n_chk++;
        if ({a_dout, a_sof, a_eof} !== {16'(16'h0100 + k), k == 1, k == 8}
            || k != nb) begin
          n_fail++;
          $display("FAIL basic_beat k=%0d act=%h sof=%b eof=%b req=%h",
                   k, a_dout, a_sof, a_eof, 16'(16'h0100 + k));
        end
      end
      if (k == 8) begin
        n_chk++;
        if (a_fid !== 16'd1) begin
          n_fail++;
          $display("FAIL basic_frame_id act=%0d exp=1", a_fid);
        end
      end
      if (k == 11 || k == 12) begin
        n_chk++;
        if (a_busy !== (k == 11)) begin
          n_fail++;
          $display("FAIL basic_busy k=%0d act=%b exp=%b", k, a_busy, k == 11);
        end
      end
    end
    n_chk++;
    if (nb != 8) begin
      n_fail++;
      $display("FAIL basic_beat_count act=%0d exp=8", nb);
    end
  endtask

  task automatic test_gappy();
    int nb = 0;
    int last_k = -1;
    drv(0, 1, 0, 0, 16'h0);
    for (int k = 1; k < 23; k++) begin
      drv(1, 0, k == 1, (k >= 2) && (k % 2 == 0), 16'(16'h0200 + k));
      n_chk++;
      if ({act_a, act_b} !== {expv(ma), expv(mb)}) begin
        n_fail++;
        $display("FAIL gappy_model k=%0d act=%h/%h exp=%h/%h",
                 k, act_a, act_b, expv(ma), expv(mb));
      end
      if (a_vld) begin
        nb++;
        last_k = k;
        n_chk++;
        if ({a_dout, a_sof, a_eof} !== {16'(16'h0200 + k), nb == 1, nb == 8}) begin
          n_fail++;
          $display("FAIL gappy_beat k=%0d act=%h sof=%b eof=%b req=%h",
                   k, a_dout, a_sof, a_eof, 16'(16'h0200 + k));
        end
      end
    end
    n_chk++;
    if (nb != 8 || last_k != 16) begin
      n_fail++;
      $display("FAIL gappy_span act=%0d beats last=%0d exp=8 beats last=16",
               nb, last_k);
    end
  endtask

  task automatic test_miss();
    int nsof = 0;
    bit t;
    drv(0, 1, 0, 0, 16'h0);
    for (int k = 0; k < 31; k++) begin
      t = (k <= 9) || k == 12 || k == 15 || k == 19 || k == 24;
      drv(1, 0, t, k % 2 == 0, 16'(16'h0300 + k));
      n_chk++;
      if ({act_a, act_b} !== {expv(ma), expv(mb)}) begin
        n_fail++;
        $display("FAIL miss_model k=%0d act=%h/%h exp=%h/%h",
                 k, act_a, act_b, expv(ma), expv(mb));
      end
      if (a_vld && a_sof) nsof++;
      if (k == 23) begin
        n_chk++;
        if ({a_miss, a_fid, a_busy} !== {16'd3, 16'd1, 1'b0}) begin
          n_fail++;
          $display("FAIL miss_count act miss=%0d fid=%0d busy=%b exp 3/1/0",
                   a_miss, a_fid, a_busy);
        end
      end
    end
    n_chk++;
    if (nsof != 2 || a_fid !== 16'd1) begin
      n_fail++;
      $display("FAIL miss_rearm act sof=%0d fid=%0d exp sof=2 fid=1",
               nsof, a_fid);
    end
  endtask

  task automatic test_clear();
    int nb1 = 0;
    int nb2 = 0;
    for (int k = 0; k < 12; k++) begin
      drv(1, 0, 0, 1, 16'(16'h0350 + k));
      n_chk++;
      if ({act_a, act_b} !== {expv(ma), expv(mb)}) begin
        n_fail++;
        $display("FAIL clear_drain k=%0d act=%h/%h exp=%h/%h",
                 k, act_a, act_b, expv(ma), expv(mb));
      end
    end
    for (int k = 0; k < 23; k++) begin
      drv(1, k == 5, k == 0 || k == 8, 1, 16'(16'h0400 + k));
      n_chk++;
      if ({act_a, act_b} !== {expv(ma), expv(mb)}) begin
        n_fail++;
        $display("FAIL clear_model k=%0d act=%h/%h exp=%h/%h",
                 k, act_a, act_b, expv(ma), expv(mb));
      end
      if (a_vld && k < 5) begin
        nb1++;
        n_chk++;
        if (a_eof !== 1'b0) begin
          n_fail++;
          $display("FAIL clear_early_eof k=%0d act=%b exp=0", k, a_eof);
        end
      end
      if (a_vld && k > 5) begin
        nb2++;
        n_chk++;
        if ({a_sof, a_eof} !== {nb2 == 1, nb2 == 8}) begin
          n_fail++;
          $display("FAIL clear_rewin k=%0d act sof=%b eof=%b", k, a_sof, a_eof);
        end
      end
      if (k == 4) begin
        n_chk++;
        if (a_miss !== 16'd3) begin
          n_fail++;
          $display("FAIL clear_pre_miss act=%0d exp=3", a_miss);
        end
      end
      if (k == 5) begin
        n_chk++;
        if ({a_vld, a_eof, a_fid, a_miss, a_busy} !== 35'h0) begin
          n_fail++;
          $display("FAIL clear_abort act vld=%b eof=%b fid=%0d miss=%0d busy=%b",
                   a_vld, a_eof, a_fid, a_miss, a_busy);
        end
      end
    end
    n_chk++;
    if (nb1 != 4 || nb2 != 8) begin
      n_fail++;
      $display("FAIL clear_beats act=%0d/%0d exp=4/8", nb1, nb2);
    end
  endtask

  task automatic test_win1();
    int nb = 0;
    for (int k = 0; k < 9; k++) begin
      drv(1, k == 0, k == 1 || k == 3, k >= 1, 16'(16'h0500 + k));
      n_chk++;
      if ({act_a, act_b} !== {expv(ma), expv(mb)}) begin
        n_fail++;
        $display("FAIL win1_model k=%0d act=%h/%h exp=%h/%h",
                 k, act_a, act_b, expv(ma), expv(mb));
      end
      if (b_vld) nb++;
      if (k == 1) begin
        n_chk++;
        if (b_vld !== 1'b0) begin
          n_fail++;
          $display("FAIL win1_trig_beat act=%b exp=0", b_vld);
        end
      end
      if (k == 2 || k == 4) begin
        n_chk++;
        if ({b_vld, b_sof, b_eof, b_dout, b_fid} !==
            {3'b111, 16'(16'h0500 + k), 16'(k / 2)}) begin
          n_fail++;
          $display("FAIL win1_beat k=%0d act vld=%b sof=%b eof=%b d=%h fid=%0d",
                   k, b_vld, b_sof, b_eof, b_dout, b_fid);
        end
      end
    end
    n_chk++;
    if (nb != 2) begin
      n_fail++;
      $display("FAIL win1_count act=%0d exp=2", nb);
    end
  endtask

  task automatic test_random();
    logic t = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) t = ~t;
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, t,
          $urandom_range(0, 9) < 6, 16'($urandom));
      n_chk++;
      if ({act_a, act_b} !== {expv(ma), expv(mb)}) begin
        n_fail++;
        $display("FAIL random_model i=%0d act=%h/%h exp=%h/%h",
                 i, act_a, act_b, expv(ma), expv(mb));
      end
    end
  endtask

  task automatic test_async_reset();
    drv(1, 1, 0, 0, 16'h0);
    for (int k = 1; k < 5; k++) drv(1, 0, k == 1, 1, 16'(16'h0600 + k));
    n_chk++;
    if (a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre_busy act=%b exp=1", a_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({act_a, act_b} !== 104'h0) begin
      n_fail++;
      $display("FAIL arst_outputs act=%h/%h exp=0", act_a, act_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drv(0, 0, k == 1 || k == 2, 1, 16'(16'h0700 + k));
      n_chk++;
      if ({act_a, act_b} !== {expv(ma), expv(mb)}) begin
        n_fail++;
        $display("FAIL arst_model k=%0d act=%h/%h exp=%h/%h",
                 k, act_a, act_b, expv(ma), expv(mb));
      end
    end
    n_chk++;
    if ({a_miss, a_busy, a_vld, b_miss, b_busy} !== 34'h0) begin
      n_fail++;
      $display("FAIL arst_en_off act miss=%0d busy=%b vld=%b exp 0",
               a_miss, a_busy, a_vld);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gappy();
    test_miss();
    test_clear();
    test_win1();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmip_trig_window_gen.md
Name: cmip_trig_window_gen

Overview:
- Downstream consumer of the delayed trigger pulse produced by the CMIP pulse-delay stage.
- Each trigger rising edge opens a capture window of exactly WIN_LEN valid samples on the acquisition stream, framed with SOF/EOF and a frame ID.
- After each window, a hold-off period applies; triggers that arrive while busy are counted as missed.
- Sits between the trigger/delay logic and the per-channel packetiser.

Parameters:
- DATA_W, 16, sample data width.
- WIN_LEN, 4096, valid samples per window; legal range 1..65535.
- HOLDOFF_CLK, 64, idle clocks after EOF before re-arm; 0 is legal.
- ID_W, 16, frame ID width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  arm enable; sampled only in IDLE.
- i_clr  in  1  synchronous abort plus counter clear.
- i_trig  in  1  delayed trigger pulse; may be multi-cycle wide.
- i_din_vld  in  1  input sample valid.
- i_din  in  DATA_W  input sample.
- o_dout_vld  out  1  windowed sample valid.
- o_dout  out  DATA_W  windowed sample.
- o_sof  out  1  first beat of window; qualified by o_dout_vld.
- o_eof  out  1  last beat of window; qualified by o_dout_vld.
- o_frame_id  out  ID_W  ID of current/next window.
- o_busy  out  1  high in CAPTURE or HOLDOFF.
- o_miss_cnt  out  16  triggers dropped while busy; saturating.

Behaviour:
- Reset: all outputs 0; state IDLE; trig_d=0; all counters 0.
- Edge detect: trig_d <= i_trig; trig_pos = i_trig & ~trig_d. A HOLD_CLK-wide pulse counts as one trigger.
- FSM states: IDLE, CAPTURE, HOLDOFF.
- IDLE: i_en & trig_pos -> CAPTURE, smp_cnt=0. The beat valid in the trigger cycle is NOT captured; capture starts with the first i_din_vld beat in the following cycle or later.
- CAPTURE, on each i_din_vld:
  - o_dout <= i_din and o_dout_vld <= 1 (1-cycle latency).
  - o_sof=1 when smp_cnt==0.
  - o_eof=1 when smp_cnt==WIN_LEN-1; on that beat frame_id increments (wraps at 2^ID_W), then -> HOLDOFF (or directly -> IDLE if HOLDOFF_CLK==0).
  - smp_cnt++ on every valid beat.
  - Gaps in i_din_vld stall the window with no timeout.
- WIN_LEN==1: o_sof and o_eof asserted on the same beat.
- HOLDOFF: hold counter loads HOLDOFF_CLK-1 on entry and decrements each clock; at 0 -> IDLE. Exactly HOLDOFF_CLK clocks are spent in HOLDOFF.
- i_en deasserted during CAPTURE/HOLDOFF: current window completes; the enable only gates new arming.
- trig_pos in CAPTURE or HOLDOFF: o_miss_cnt++ (saturates at 0xFFFF); the trigger is otherwise ignored.
- trig_pos in IDLE with i_en=0: ignored, not counted.
- i_clr (priority over everything except reset):
  - Next state IDLE.
  - smp_cnt, hold counter, frame_id and o_miss_cnt cleared.
  - o_dout_vld/o_sof/o_eof forced 0 next cycle; no EOF is emitted for an aborted window.
  - A trig_pos coincident with i_clr is discarded.
- o_busy is registered; it goes high the cycle after the arming trig_pos and low the cycle IDLE is re-entered.
- o_dout holds its last value when o_dout_vld=0.
- smp_cnt width = $clog2(WIN_LEN+1). Compare against WIN_LEN-1 using a localparam of matching width; no truncation warnings are permitted.

Decomposition:
- Shared cmip package: state encoding localparams (IDLE=2'd0, CAPTURE=2'd1, HOLDOFF=2'd2) and the default WIN_LEN/HOLDOFF_CLK constants used by top-level instantiation.
- No sub-module. The edge detector and saturating counter are inline, and the block stays a single file of about 200 lines.

Test Plan:
- WIN_LEN=8, HOLDOFF_CLK=4, i_en=1, continuous valid, data = incrementing from 0x0100, trigger at t0 -> outputs 0x0101..0x0108 on consecutive cycles starting t0+2; sof on 0x0101, eof on 0x0108; frame_id 0->1; o_busy low 4 clocks after eof.
- Same window size, i_din_vld toggling 1/0 -> exactly 8 output beats spread over 16 cycles; sof/eof on first/last valid beats only.
- 10-cycle-wide i_trig pulse, then 3 further pulses during CAPTURE/HOLDOFF -> one window captured; o_miss_cnt=3; next pulse after HOLDOFF starts frame_id=1.
- i_clr asserted at capture beat 5 of 8 -> no eof; o_dout_vld low next cycle; frame_id=0; miss_cnt=0; next trigger gives a full 8-beat window with sof.
- WIN_LEN=1, HOLDOFF_CLK=0 -> single beat with sof=eof=1; re-trigger 2 cycles later is accepted, giving frame_id=2 after the second window.
- Async reset pulled mid-CAPTURE -> all outputs 0 immediately; after release, trigger with i_en=0 is ignored and miss_cnt stays 0.
